// File: rtl/sys_ctrl_v2.sv
// Command controller for the REF clock domain: parses RX byte frames into register-file,
// ALU and clock-gate actions and streams results to the TX FIFO. Optional macro: CMD_TIMEOUT_EN.
module sys_ctrl_v2 #(
  parameter int DSIZE          = 8,
  parameter int ASIZE          = 4,
  parameter int OPSIZE         = 8,
  parameter int OUT_SIZE       = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [DSIZE-1:0]    RX_P_DATA,
  input  logic                RX_D_VLD,
  input  logic [OUT_SIZE-1:0] ALU_OUT,
  input  logic                OUT_VALID,
  input  logic [DSIZE-1:0]    RdData,
  input  logic                RdData_Valid,
  input  logic                FIFO_FULL,
  output logic                ALU_EN,
  output logic [3:0]          ALU_FUN,
  output logic                GATE_EN,
  output logic [ASIZE-1:0]    Address,
  output logic                WrEn,
  output logic                RdEn,
  output logic [DSIZE-1:0]    WrData,
  output logic [DSIZE-1:0]    FIFO_WR_DATA,
  output logic                FIFO_W_INC,
  output logic                ERR_PULSE
);

  localparam int NBYTES = OUT_SIZE / DSIZE;
  localparam int CW     = $clog2(NBYTES + 1);
  localparam logic [DSIZE-1:0] CMD_WR      = DSIZE'(8'hAA);
  localparam logic [DSIZE-1:0] CMD_RD      = DSIZE'(8'hBB);
  localparam logic [DSIZE-1:0] CMD_ALU_OP  = DSIZE'(8'hCC);
  localparam logic [DSIZE-1:0] CMD_ALU_NOP = DSIZE'(8'hDD);

  if (ASIZE > DSIZE || OPSIZE != DSIZE || (OUT_SIZE % DSIZE) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("sys_ctrl_v2: illegal parameter set");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT,
    S_OP_A, S_OP_B, S_ALU_FUN, S_ALU_WAIT, S_TX
  } state_t;

  state_t                state_r, state_s;
  logic [OUT_SIZE-1:0]   buf_r, buf_s, load_val_s;
  logic [CW-1:0]         cnt_r, cnt_s, load_cnt_s;
  logic                  load_s;
  logic [ASIZE-1:0]      addr_r, addr_s;
  logic [DSIZE-1:0]      wr_data_r, wr_data_s, fifo_data_r, fifo_data_s;
  logic [3:0]            alu_fun_r, alu_fun_s;
  logic                  wr_en_r, wr_en_s, rd_en_r, rd_en_s, alu_en_r, alu_en_s;
  logic                  gate_en_r, gate_en_s, fifo_inc_r, fifo_inc_s, err_r, err_s;

`ifdef CMD_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
  logic [GW-1:0] gap_r;
  logic          waiting_s, timeout_s;

  assign waiting_s = (state_r inside {S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_OP_A, S_OP_B, S_ALU_FUN});
  assign timeout_s = waiting_s && !RX_D_VLD && (gap_r == GW'(TIMEOUT_CYCLES - 1));

  // Inter-byte gap counter, cleared by every received byte and outside frame-wait states
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      gap_r <= '0;
    end else if (!waiting_s || RX_D_VLD || timeout_s) begin
      gap_r <= '0;
    end else begin
      gap_r <= gap_r + GW'(1);
    end
  end
`endif

  // FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, result buffer and output-register next values
  always_comb begin
    state_s     = state_r;
    buf_s       = buf_r;
    cnt_s       = cnt_r;
    addr_s      = addr_r;
    wr_data_s   = wr_data_r;
    alu_fun_s   = alu_fun_r;
    alu_en_s    = alu_en_r;
    gate_en_s   = gate_en_r;
    fifo_data_s = fifo_data_r;
    wr_en_s     = 1'b0;
    rd_en_s     = 1'b0;
    fifo_inc_s  = 1'b0;
    err_s       = 1'b0;
    load_s      = 1'b0;
    load_val_s  = '0;
    load_cnt_s  = '0;
    case (state_r)
      S_IDLE: begin
        if (RX_D_VLD) begin
          case (RX_P_DATA)
            CMD_WR:      state_s = S_WR_ADDR;
            CMD_RD:      state_s = S_RD_ADDR;
            CMD_ALU_OP:  state_s = S_OP_A;
            CMD_ALU_NOP: state_s = S_ALU_FUN;
            default:     err_s   = 1'b1;
          endcase
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_s  = RX_P_DATA[ASIZE-1:0];
          state_s = S_WR_DATA;
        end else begin
          state_s = S_WR_ADDR;
        end
      end
      S_WR_DATA: begin
        if (RX_D_VLD) begin
          wr_en_s   = 1'b1;
          wr_data_s = RX_P_DATA;
          state_s   = S_IDLE;
        end else begin
          state_s = S_WR_DATA;
        end
      end
      S_RD_ADDR: begin
        if (RX_D_VLD) begin
          addr_s  = RX_P_DATA[ASIZE-1:0];
          rd_en_s = 1'b1;
          state_s = S_RD_WAIT;
        end else begin
          state_s = S_RD_ADDR;
        end
      end
      S_RD_WAIT: begin
        if (RdData_Valid) begin
          load_s     = 1'b1;
          load_val_s = OUT_SIZE'(RdData);
          load_cnt_s = CW'(1);
        end else begin
          state_s = S_RD_WAIT;
        end
      end
      S_OP_A, S_OP_B: begin
        if (RX_D_VLD) begin
          wr_en_s   = 1'b1;
          wr_data_s = DSIZE'(RX_P_DATA[OPSIZE-1:0]);
          addr_s    = (state_r == S_OP_A) ? ASIZE'(0) : ASIZE'(1);
          state_s   = (state_r == S_OP_A) ? S_OP_B : S_ALU_FUN;
        end else begin
          state_s = state_r;
        end
      end
      S_ALU_FUN: begin
        if (RX_D_VLD) begin
          alu_fun_s = RX_P_DATA[3:0];
          alu_en_s  = 1'b1;
          gate_en_s = 1'b1;
          state_s   = S_ALU_WAIT;
        end else begin
          state_s = S_ALU_FUN;
        end
      end
      S_ALU_WAIT: begin
        if (OUT_VALID) begin
          alu_en_s   = 1'b0;
          gate_en_s  = 1'b0;
          load_s     = 1'b1;
          load_val_s = ALU_OUT;
          load_cnt_s = CW'(NBYTES);
        end else begin
          state_s = S_ALU_WAIT;
        end
      end
      S_TX: begin
        if (!FIFO_FULL) begin
          fifo_inc_s  = 1'b1;
          fifo_data_s = buf_r[DSIZE-1:0];
          buf_s       = buf_r >> DSIZE;
          cnt_s       = cnt_r - CW'(1);
          state_s     = (cnt_r == CW'(1)) ? S_IDLE : S_TX;
        end else begin
          state_s = S_TX;
        end
      end
      default: state_s = S_IDLE;
    endcase
    // A fresh result pushes its first byte straight away when the FIFO has room
    if (load_s) begin
      if (!FIFO_FULL) begin
        fifo_inc_s  = 1'b1;
        fifo_data_s = load_val_s[DSIZE-1:0];
        buf_s       = load_val_s >> DSIZE;
        cnt_s       = load_cnt_s - CW'(1);
        state_s     = (load_cnt_s == CW'(1)) ? S_IDLE : S_TX;
      end else begin
        buf_s   = load_val_s;
        cnt_s   = load_cnt_s;
        state_s = S_TX;
      end
    end else begin
      load_val_s = '0;
    end
`ifdef CMD_TIMEOUT_EN
    if (timeout_s) begin
      state_s = S_IDLE;
      err_s   = 1'b1;
    end else begin
      err_s = err_s;
    end
`endif
  end

  // Datapath and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      buf_r       <= '0;
      cnt_r       <= '0;
      addr_r      <= '0;
      wr_data_r   <= '0;
      alu_fun_r   <= 4'd0;
      alu_en_r    <= 1'b0;
      gate_en_r   <= 1'b0;
      fifo_data_r <= '0;
      wr_en_r     <= 1'b0;
      rd_en_r     <= 1'b0;
      fifo_inc_r  <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      buf_r       <= buf_s;
      cnt_r       <= cnt_s;
      addr_r      <= addr_s;
      wr_data_r   <= wr_data_s;
      alu_fun_r   <= alu_fun_s;
      alu_en_r    <= alu_en_s;
      gate_en_r   <= gate_en_s;
      fifo_data_r <= fifo_data_s;
      wr_en_r     <= wr_en_s;
      rd_en_r     <= rd_en_s;
      fifo_inc_r  <= fifo_inc_s;
      err_r       <= err_s;
    end
  end

  assign ALU_EN       = alu_en_r;
  assign ALU_FUN      = alu_fun_r;
  assign GATE_EN      = gate_en_r;
  assign Address      = addr_r;
  assign WrEn         = wr_en_r;
  assign RdEn         = rd_en_r;
  assign WrData       = wr_data_r;
  assign FIFO_WR_DATA = fifo_data_r;
  assign FIFO_W_INC   = fifo_inc_r;
  assign ERR_PULSE    = err_r;

endmodule
